// File: rtl/uart_rx_mmio.sv
// 8N1 serial receiver with a small byte FIFO, read over the core's memory bus (data at BASE_ADDR, status at +4).
// Read data is registered one cycle after the request; a full FIFO drops new bytes and flags overrun.
module uart_rx_mmio #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          CLK_DIV   = 100,
    parameter int          FIFO_LOG2 = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic        mem_valid,
    input  logic        mem_write,
    input  logic [3:0]  mem_wmask,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] mem_addr,
    output logic [31:0] mem_rdata,
    output logic        irq
);
    localparam int              DEPTH   = 1 << FIFO_LOG2;
    localparam logic [15:0]     HALF_LD = 16'(CLK_DIV / 2 - 1);
    localparam logic [15:0]     BIT_LD  = 16'(CLK_DIV - 1);
    localparam logic [FIFO_LOG2:0] PTR_ONE = (FIFO_LOG2 + 1)'(1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    logic                 rx_meta_q, rx_s_q;
    state_t               state_q;
    logic [15:0]          cnt_q;
    logic [2:0]           idx_q;
    logic [7:0]           shreg_q;
    logic [FIFO_LOG2:0]   wptr_q, rptr_q;
    logic [7:0]           fifo_mem [DEPTH];
    logic                 overrun_q, overrun_d;
    logic                 frame_err_q, frame_err_d;
    logic [31:0]          rdata_q, rdata_d;

    logic tick, push_ev, ferr_ev, empty, full;
    logic sel, rd_data, rd_stat, wr_stat, pop, do_push, ovf_ev;
    logic [7:0] head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    assign tick    = (cnt_q == 16'd0);
    assign push_ev = (state_q == S_STOP) && tick && rx_s_q;
    assign ferr_ev = (state_q == S_STOP) && tick && !rx_s_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            shreg_q <= 8'd0;
        end else begin
            if (state_q != S_IDLE)
                cnt_q <= cnt_q - 16'd1;
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        cnt_q   <= HALF_LD;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        if (rx_s_q) begin
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q   <= BIT_LD;
                            idx_q   <= 3'd0;
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        shreg_q[idx_q] <= rx_s_q;
                        cnt_q          <= BIT_LD;
                        idx_q          <= idx_q + 3'd1;
                        if (idx_q == 3'd7)
                            state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (tick)
                        state_q <= rx_s_q ? S_IDLE : S_BREAK;
                end
                S_BREAK: begin
                    if (rx_s_q)
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign empty = (wptr_q == rptr_q);
    assign full  = ((wptr_q ^ rptr_q) == {1'b1, {FIFO_LOG2{1'b0}}});
    assign head  = fifo_mem[rptr_q[FIFO_LOG2-1:0]];

    assign sel     = mem_valid && (mem_addr[31:3] == BASE_ADDR[31:3]);
    assign rd_data = sel && !mem_write && !mem_addr[2];
    assign rd_stat = sel && !mem_write && mem_addr[2];
    assign wr_stat = sel && mem_write && mem_addr[2] && mem_wmask[0];
    assign pop     = rd_data && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push_ev && (!full || pop);
    assign ovf_ev  = push_ev && full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PTR_ONE;
            if (pop)     rptr_q <= rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            fifo_mem[wptr_q[FIFO_LOG2-1:0]] <= shreg_q;
    end

    always_comb begin
        overrun_d = overrun_q;
        if (wr_stat && mem_wdata[1]) overrun_d = 1'b0;
        if (ovf_ev)                  overrun_d = 1'b1;

        frame_err_d = frame_err_q;
        if (wr_stat && mem_wdata[2]) frame_err_d = 1'b0;
        if (ferr_ev)                 frame_err_d = 1'b1;

        rdata_d = 32'd0;
        if (rd_data && !empty)
            rdata_d = {23'd0, 1'b1, head};
        else if (rd_stat)
            rdata_d = {28'd0, full, frame_err_q, overrun_q, !empty};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rdata_q     <= 32'd0;
        end else begin
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            rdata_q     <= rdata_d;
        end
    end

    assign mem_rdata = rdata_q;
    assign irq       = !empty;

    logic unused_ok;
    assign unused_ok = ^{mem_wmask[3:1], mem_wdata[31:3], mem_wdata[0], mem_addr[1:0]};
endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed bench for uart_rx_mmio with an 8-cycle bit period and a 4-deep FIFO.
module tb_uart_rx_mmio;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst, rx, mem_valid, mem_write, irq;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata, mem_addr, mem_rdata;
    logic [31:0] d;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    uart_rx_mmio #(.BASE_ADDR(BASE), .CLK_DIV(8), .FIFO_LOG2(2)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .mem_valid(mem_valid), .mem_write(mem_write), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .irq(irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] rd);
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_write = 1'b0; mem_addr = a;
        @(posedge clk); #1;
        mem_valid = 1'b0;
        rd = mem_rdata;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm);
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_write = 1'b1; mem_addr = a; mem_wdata = wd; mem_wmask = wm;
        @(posedge clk); #1;
        mem_valid = 1'b0; mem_write = 1'b0; mem_wmask = 4'h0;
    endtask

    // Start bit goes low one step after the first edge; stop bit is left on the line.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (8) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; rx = 1'b1; mem_valid = 1'b0; mem_write = 1'b0;
        mem_wmask = 4'h0; mem_wdata = 32'h0; mem_addr = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", mem_rdata, 32'h0);
        chk("rst_irq", {31'd0, irq}, 32'h0);
        rst = 1'b0;
        bus_read(BASE + 32'd4, d); chk("rst_status", d, 32'h0);

        // Single byte: stop sample lands on the 80th edge of the frame.
        fork
            send_frame(8'h55, 1'b1);
            begin
                repeat (79) @(posedge clk);
                #1 chk("irq_before_stop", {31'd0, irq}, 32'h0);
                @(posedge clk);
                #1 chk("irq_after_stop", {31'd0, irq}, 32'h1);
            end
        join
        bus_read(BASE + 32'd4, d); chk("single_status", d, 32'h1);
        bus_read(BASE, d);         chk("single_data", d, 32'h155);
        @(posedge clk); #1 chk("rdata_idle_zero", mem_rdata, 32'h0);
        bus_read(BASE + 32'd4, d); chk("single_status_after", d, 32'h0);
        chk("single_irq_low", {31'd0, irq}, 32'h0);

        // Glitch
        @(posedge clk); #1 rx = 1'b0;
        repeat (2) @(posedge clk);
        #1 rx = 1'b1;
        repeat (20) @(posedge clk);
        bus_read(BASE + 32'd4, d); chk("glitch_status", d, 32'h0);

        // Framing error followed by a held break
        send_frame(8'hA3, 1'b0);
        repeat (12) @(posedge clk);
        #1 rx = 1'b1;
        repeat (6) @(posedge clk);
        bus_read(BASE + 32'd4, d); chk("frame_status", d, 32'h4);
        bus_read(BASE, d);         chk("frame_fifo_empty", d, 32'h0);
        bus_write(BASE + 32'd4, 32'h4, 4'h1);
        bus_read(BASE + 32'd4, d); chk("frame_cleared", d, 32'h0);

        // Overrun
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
        repeat (2) @(posedge clk);
        bus_read(BASE + 32'd4, d); chk("ovr_status", d, 32'hB);
        for (int b = 1; b <= 4; b++) begin
            bus_read(BASE, d); chk("ovr_data", d, 32'h100 | 32'(b));
        end
        bus_read(BASE, d);         chk("ovr_empty_read", d, 32'h0);
        bus_write(BASE + 32'd4, 32'h2, 4'h1);
        bus_read(BASE + 32'd4, d); chk("ovr_cleared", d, 32'h0);

        // Push/pop collision on a full FIFO
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        bus_read(BASE + 32'd4, d); chk("col_full_status", d, 32'h9);
        fork
            send_frame(8'h77, 1'b1);
            begin
                repeat (79) @(posedge clk);
                #1;
                mem_valid = 1'b1; mem_write = 1'b0; mem_addr = BASE;
                @(posedge clk); #1;
                mem_valid = 1'b0;
                chk("col_pop_data", mem_rdata, 32'h111);
            end
        join
        bus_read(BASE + 32'd4, d); chk("col_status", d, 32'h9);
        bus_read(BASE, d); chk("col_d1", d, 32'h122);
        bus_read(BASE, d); chk("col_d2", d, 32'h133);
        bus_read(BASE, d); chk("col_d3", d, 32'h144);

        // Decode: out-of-window read and data-register write have no effect
        bus_read(BASE + 32'd8, d);  chk("dec_rdata", d, 32'h0);
        bus_read(BASE + 32'd4, d);  chk("dec_no_pop", d, 32'h1);
        bus_write(BASE, 32'hFF, 4'hF);
        bus_read(BASE + 32'd4, d);  chk("dec_wr0_ignored", d, 32'h1);
        bus_read(BASE, d);          chk("col_last", d, 32'h177);

        // Reset in the middle of a frame with a byte waiting
        send_frame(8'h42, 1'b1);
        chk("pre_rst_irq", {31'd0, irq}, 32'h1);
        @(posedge clk); #1 rx = 1'b0;
        repeat (20) @(posedge clk);
        bus_read(BASE + 32'd4, d); chk("pre_rst_status", d, 32'h1);
        rst = 1'b1; rx = 1'b1;
        #1;
        chk("midrst_rdata", mem_rdata, 32'h0);
        chk("midrst_irq", {31'd0, irq}, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        bus_read(BASE + 32'd4, d); chk("post_rst_status", d, 32'h0);
        send_frame(8'h5A, 1'b1);
        bus_read(BASE, d);         chk("post_rst_data", d, 32'h15A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_mmio.md
Name: uart_rx_mmio

Overview:
- Memory-mapped serial character receiver: the input counterpart of the character-output port at 0x1000_0000.
- Deserialises an 8N1 serial line into a small FIFO. The core reads received bytes over the same valid/write/wmask/addr/wdata/rdata bus used by the core's memory port.
- Sits beside the memory on the core's data bus. Its rdata is zero when not selected, so the system bus can OR it with other responders.

Parameters:
- BASE_ADDR, 32'h1000_0000, byte address of the data register; the status register is at BASE_ADDR+4.
- CLK_DIV, 100, clock cycles per serial bit (range 4..65535).
- FIFO_LOG2, 3, log2 of FIFO depth (default 8 entries).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rx  in  1  serial input, idles high; asynchronous to clk.
- mem_valid  in  1  bus request.
- mem_write  in  1  1 = write, 0 = read.
- mem_wmask  in  4  byte write mask.
- mem_wdata  in  32  write data.
- mem_addr  in  32  byte address.
- mem_rdata  out  32  read data, valid one cycle after the request.
- irq  out  1  high while the FIFO is non-empty.

Behaviour:
- Reset (async, rst=1):
  - mem_rdata=0, irq=0.
  - FIFO empty, overrun=0, frame_err=0.
  - State IDLE; synchroniser flops set to 1.
- Input synchronisation: rx passes through a 2-flop synchroniser (rx_s). All decoding uses rx_s.
- Receive FSM (counter cnt, 16 bits; bit index 0..7):
  - IDLE: when rx_s=0, load cnt=CLK_DIV/2-1 and go to START.
  - START: at cnt=0, sample rx_s.
    - 1: false start, go to IDLE.
    - 0: load cnt=CLK_DIV-1, idx=0, go to DATA.
  - DATA: at cnt=0, shift rx_s into shreg[idx] (LSB first) and reload cnt. After idx=7, go to STOP.
  - STOP: at cnt=0, sample rx_s.
    - 1: push shreg into the FIFO, go to IDLE.
    - 0: set frame_err, discard the byte, go to BREAK.
  - BREAK: wait for rx_s=1, then go to IDLE.
  - cnt decrements every cycle in every non-IDLE state.
- FIFO (2^FIFO_LOG2 x 8): pointers are FIFO_LOG2+1 bits wide and wrap naturally. Full when pointers differ only in the MSB.
  - Push when full: byte dropped, overrun set. Exception: if a pop occurs in the same cycle, both the push and the pop happen and overrun is not set.
  - Push and pop in the same cycle when non-empty: both occur, count unchanged.
- Bus decode: sel = mem_valid & (mem_addr[31:3] == BASE_ADDR[31:3]). Accesses outside BASE_ADDR..BASE_ADDR+7 are ignored and return rdata 0.
- Read of data register (offset 0, mem_write=0):
  - FIFO non-empty: next cycle mem_rdata = {23'b0, 1'b1, head}. The pop happens on the request edge.
  - FIFO empty: next cycle mem_rdata = 0; no pop.
- Read of status register (offset 4): next cycle mem_rdata = {28'b0, full, frame_err, overrun, ~empty}. No side effects.
- Write of status register (offset 4, mem_write=1, mem_wmask[0]=1) is write-1-to-clear:
  - wdata[1]=1 clears overrun.
  - wdata[2]=1 clears frame_err.
  - If a set event occurs in the same cycle as a clear, the set wins.
- Writes to offset 0 are ignored.
- mem_rdata is 0 in every cycle not immediately following a selected read.
- Latency: a byte appears in status.bit0 and irq on the cycle after the rising edge that samples a valid stop bit.
- Reset mid-frame: the partial byte is discarded and FIFO contents are lost.

Test Plan:
- Single byte: CLK_DIV=8, send 0x55 (8N1). Then:
  - irq rises after the stop sample.
  - Status read returns 0x1.
  - Data read returns 0x155; next status read returns 0x0; irq=0.
- Glitch: rx low for 2 cycles with CLK_DIV=8 -> START samples 1, returns to IDLE; FIFO stays empty, no flags set.
- Framing: send 0xA3 with stop bit 0, hold rx low for 20 cycles, then high.
  - Status returns 0x4; FIFO empty.
  - Write 0x4 to BASE_ADDR+4 -> status returns 0x0.
- Overrun: FIFO_LOG2=2, send 0x01..0x05 without reading.
  - Status returns 0xB (full, overrun, non-empty).
  - Four data reads return 0x101, 0x102, 0x103, 0x104; a fifth read returns 0x000.
- Push/pop collision: fill the FIFO (depth 4), then issue a data read on the exact stop-sample cycle of byte 0x77 -> no overrun; the last read returns 0x177.
- Decode/reset: read BASE_ADDR+8 -> rdata 0 and no pop. Assert rst mid-frame -> rdata 0, irq 0, FIFO empty; the next byte 0x5A is received correctly.
